bram_image_reader: RTL and testbench

- Read-side counterpart of bram_storage.
- Once a 28x28 image (784 bytes) has been written, it requests read access, sweeps addresses 0..783 and absorbs the BRAM read latency.
- Delivers pixels in order as a valid/ready byte stream to the input layer of the neural network.
- Exactly one stream per completed image write.

---
 rtl/nn_input_pkg.sv | 19 +
 rtl/pixel_skid_fifo.sv | 62 ++++++
 rtl/bram_image_reader.sv | 136 +++++++++++++
 tb/tb_bram_image_reader.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_input_pkg.sv
// Shared types and image geometry for the neural-network input path.
package nn_input_pkg;

  localparam int unsigned IMG_W      = 28;
  localparam int unsigned IMG_H      = 28;
  localparam int unsigned IMG_PIXELS = IMG_W * IMG_H;

  typedef logic [7:0]  pixel_t;
  typedef logic [15:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    STREAM,
    DRAIN,
    DONE
  } reader_state_e;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Shift-register FIFO for pixels plus last flag; the head always sits in entry 0,
// so the streamed pixel comes straight from a register.
module pixel_skid_fifo #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 2,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic              head_valid,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  last_q;
  logic [CNT_W-1:0]  wr_idx;
  logic [CNT_W-1:0]  count_next;

  always_comb begin
    wr_idx     = count - CNT_W'(pop);
    count_next = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Pop shifts everything down; a push lands behind the surviving entries.
  // Last flags of empty slots are cleared so a stale flag never reaches the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      last_q     <= '0;
      count      <= '0;
      head_valid <= 1'b0;
    end else begin
      count      <= count_next;
      head_valid <= (count_next != '0);
      if (pop) begin
        for (int i = 0; i < int'(DEPTH) - 1; i++) begin
          mem[i]    <= mem[i+1];
          last_q[i] <= (CNT_W'(i + 1) < count) & last_q[i+1];
        end
        last_q[DEPTH-1] <= 1'b0;
      end
      if (push) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (wr_idx == CNT_W'(i)) begin
            mem[i]    <= push_data;
            last_q[i] <= push_last;
          end
        end
      end
    end
  end

  assign head_data = mem[0];
  assign head_last = last_q[0];

endmodule

// File: rtl/bram_image_reader.sv
// Reads one stored image out of BRAM per image_written rising edge and streams
// it as a valid/ready pixel stream, hiding the BRAM read latency behind a small FIFO.
module bram_image_reader
  import nn_input_pkg::reader_state_e, nn_input_pkg::IDLE, nn_input_pkg::REQ,
         nn_input_pkg::STREAM, nn_input_pkg::DRAIN, nn_input_pkg::DONE;
#(
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned IMG_PIXELS = 784,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              image_written,
  output logic              read_request,
  input  logic              read_enable,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last,
  output logic              frame_done,
  output logic              busy
);

  localparam int unsigned SUM_W = $clog2(FIFO_DEPTH + RD_LATENCY + 2);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_PIXELS - 1);

  reader_state_e         state;
  logic                  iw_q;
  logic [RD_LATENCY-1:0] pipe_v;
  logic [RD_LATENCY-1:0] pipe_l;
  logic [CNT_W-1:0]      fifo_count;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  credit_ok;
  logic                  issue;
  logic [SUM_W-1:0]      in_flight;
  logic [SUM_W-1:0]      in_flight_n;

  always_comb begin
    in_flight = '0;
    for (int i = 0; i < int'(RD_LATENCY); i++) in_flight = in_flight + SUM_W'(pipe_v[i]);
  end

  // A pixel leaving the FIFO this cycle frees a slot, which keeps 1 pixel/cycle.
  assign fifo_push   = pipe_v[RD_LATENCY-1];
  assign fifo_pop    = pix_valid & pix_ready;
  assign credit_ok   = (SUM_W'(fifo_count) + in_flight) < (SUM_W'(FIFO_DEPTH) + SUM_W'(fifo_pop));
  assign issue       = (state == STREAM) & read_enable & credit_ok;
  assign in_flight_n = in_flight - SUM_W'(fifo_push) + SUM_W'(issue);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v <= '0;
      pipe_l <= '0;
    end else begin
      pipe_v[0] <= issue;
      pipe_l[0] <= issue & (addr == LAST_ADDR);
      for (int i = 1; i < int'(RD_LATENCY); i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_l[i] <= pipe_l[i-1];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      iw_q         <= 1'b0;
      read_request <= 1'b0;
      addr         <= '0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      iw_q       <= image_written;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (image_written && !iw_q) begin
            state        <= REQ;
            read_request <= 1'b1;
            busy         <= 1'b1;
          end
        end
        REQ: begin
          if (read_enable) begin
            state <= STREAM;
            addr  <= '0;
          end
        end
        STREAM: begin
          if (issue) begin
            if (addr == LAST_ADDR) state <= DRAIN;
            else                   addr  <= addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          // Hold read ownership until every outstanding read has returned.
          read_request <= (in_flight_n != '0);
          if (fifo_pop && pix_last) begin
            state      <= DONE;
            frame_done <= 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          addr         <= '0;
          busy         <= 1'b0;
          read_request <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  pixel_skid_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fifo_push),
    .push_data  (data_in),
    .push_last  (pipe_l[RD_LATENCY-1]),
    .pop        (fifo_pop),
    .head_data  (pix_data),
    .head_last  (pix_last),
    .head_valid (pix_valid),
    .count      (fifo_count)
  );

endmodule

// File: tb/tb_bram_image_reader.sv
// Bench for bram_image_reader: BRAM model with mem[i]=i[7:0], scoreboard of expected pixels.
module tb_bram_image_reader;

  localparam int NPIX = 784;

  logic       clk;
  logic       rst_n;
  logic       image_written, read_request, read_enable, grant_q, re_block;
  logic [15:0] addr;
  logic [7:0] data_in, pix_data;
  logic       pix_valid, pix_ready, pix_last, frame_done, busy;

  logic       image_written2, read_request2, read_enable2, grant2_q;
  logic [15:0] addr2;
  logic [7:0] data_in2, dq2, pix_data2;
  logic       pix_valid2, pix_ready2, pix_last2, frame_done2, busy2;

  int total = 0;
  int bad   = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp2_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bram_image_reader dut (
    .clk(clk), .rst_n(rst_n), .image_written(image_written), .read_request(read_request),
    .read_enable(read_enable), .addr(addr), .data_in(data_in), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
    .frame_done(frame_done), .busy(busy)
  );

  bram_image_reader #(.RD_LATENCY(2), .FIFO_DEPTH(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .image_written(image_written2), .read_request(read_request2),
    .read_enable(read_enable2), .addr(addr2), .data_in(data_in2), .pix_data(pix_data2),
    .pix_valid(pix_valid2), .pix_ready(pix_ready2), .pix_last(pix_last2),
    .frame_done(frame_done2), .busy(busy2)
  );

  // bram_storage stand-in: grant one cycle after request, read data mem[a]=a[7:0].
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q  <= 1'b0;
      grant2_q <= 1'b0;
      data_in  <= 8'h00;
      dq2      <= 8'h00;
      data_in2 <= 8'h00;
    end else begin
      grant_q  <= read_request;
      grant2_q <= read_request2;
      data_in  <= addr[7:0];
      dq2      <= addr2[7:0];
      data_in2 <= dq2;
    end
  end

  assign read_enable  = grant_q & ~re_block;
  assign read_enable2 = grant2_q;

  task automatic expect_frame();
    for (int i = 0; i < NPIX; i++) begin
      logic [8:0] e;
      e = {1'(i == NPIX - 1), 8'(i)};
      exp_q.push_back(e);
    end
  endtask

  // Drives one frame on dut: start edge must already be applied by the caller.
  task automatic run_frame(input bit hold_iw, input bit rand_rdy, input int block_at,
                           input int rst_at, output int npix, output int lat, output int span);
    logic [8:0] e;
    logic [7:0] held;
    bit stall, fin, ovf, blocked_done;
    int g, fv, last_c, done_cnt, blk;
    npix = 0; lat = -1; span = -1;
    stall = 0; fin = 0; ovf = 0; blocked_done = 0;
    g = -1; fv = -1; last_c = -1; done_cnt = 0; blk = 0; held = 8'h00;
    for (int c = 0; c < 8000 && !fin; c++) begin
      @(posedge clk); #1;
      if (c == 0 && !hold_iw) image_written = 1'b0;
      if (rst_at >= 0 && npix == rst_at) begin
        fin = 1;
      end else begin
        if (g < 0 && read_request && read_enable) g = c;
        if (blk > 0) begin
          total++;
          if (addr !== 16'(block_at)) $display("FAIL addr_hold: got %0d want %0d", addr, block_at);
          blk--;
          if (blk == 0) begin re_block = 1'b0; blocked_done = 1; end
        end else if (block_at >= 0 && !blocked_done && read_enable && addr == 16'(block_at)) begin
          re_block = 1'b1;
          blk = 10;
        end
        pix_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (stall) begin
          total++;
          if (pix_valid !== 1'b1 || pix_data !== held) begin
            bad++;
            $display("FAIL stall_stable: got valid=%0b data=%02h want valid=1 data=%02h", pix_valid, pix_data, held);
          end
        end
        if (dut.fifo_push && !dut.fifo_pop && int'(dut.fifo_count) == 2) ovf = 1;
        if (frame_done === 1'b1) done_cnt++;
        if (last_c >= 0 && c == last_c + 1) begin
          total++;
          if (frame_done !== 1'b1) begin bad++; $display("FAIL frame_done_pulse: got %0b want 1", frame_done); end
        end
        if (last_c >= 0 && c == last_c + 2) begin
          total++;
          if (busy !== 1'b0 || frame_done !== 1'b0 || read_request !== 1'b0) begin
            bad++;
            $display("FAIL post_frame_idle: got busy=%0b done=%0b req=%0b want 0 0 0", busy, frame_done, read_request);
          end
          fin = 1;
        end
        if (!fin && pix_valid && pix_ready) begin
          if (fv < 0) fv = c;
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL extra_pixel: got data=%02h want none", pix_data);
          end else begin
            e = exp_q.pop_front();
            if ({pix_last, pix_data} !== e) begin
              bad++;
              $display("FAIL pixel[%0d]: got last=%0b data=%02h want last=%0b data=%02h", npix, pix_last, pix_data, e[8], e[7:0]);
            end
          end
          if (pix_last) last_c = c;
          npix++;
        end
        stall = pix_valid && !pix_ready;
        held  = pix_data;
      end
    end
    re_block = 1'b0;
    if (g >= 0 && fv >= 0) lat = fv - g - 1;
    if (last_c >= 0 && fv >= 0) span = last_c - fv;
    if (rst_at < 0) begin
      total++;
      if (!fin) begin bad++; $display("FAIL frame_timeout: got npix=%0d want %0d", npix, NPIX); end
      total++;
      if (done_cnt != 1) begin bad++; $display("FAIL frame_done_count: got %0d want 1", done_cnt); end
      total++;
      if (ovf) begin bad++; $display("FAIL fifo_overflow: got push into full want none"); end
      total++;
      if (exp_q.size() != 0) begin bad++; $display("FAIL missing_pixels: got %0d left want 0", exp_q.size()); end
      if (block_at >= 0) begin
        total++;
        if (!blocked_done) begin bad++; $display("FAIL grant_drop: got no hold at %0d want hold", block_at); end
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    total++;
    if ({read_request, addr, pix_data, pix_valid, pix_last, frame_done, busy} !== '0) begin
      bad++;
      $display("FAIL %s: got req=%0b addr=%0d data=%02h valid=%0b last=%0b done=%0b busy=%0b want all 0",
               tag, read_request, addr, pix_data, pix_valid, pix_last, frame_done, busy);
    end
  endtask

  task automatic start_edge();
    @(posedge clk); #1;
    image_written = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    total++;
    if ({read_request2, pix_valid2, busy2, addr2} !== '0) begin
      bad++;
      $display("FAIL reset_outputs2: got req=%0b valid=%0b busy=%0b addr=%0d want 0", read_request2, pix_valid2, busy2, addr2);
    end
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_basic_frame();
    int n, lat, span;
    expect_frame();
    start_edge();
    run_frame(1'b0, 1'b0, -1, -1, n, lat, span);
    total++;
    if (n != NPIX) begin bad++; $display("FAIL basic_count: got %0d want %0d", n, NPIX); end
    total++;
    if (lat != 2) begin bad++; $display("FAIL basic_first_valid: got %0d want 2", lat); end
    total++;
    if (span != NPIX - 1) begin bad++; $display("FAIL basic_throughput: got span %0d want %0d", span, NPIX - 1); end
  endtask

  task automatic test_random_ready();
    int n, lat, span;
    expect_frame();
    start_edge();
    run_frame(1'b0, 1'b1, -1, -1, n, lat, span);
    total++;
    if (n != NPIX) begin bad++; $display("FAIL random_count: got %0d want %0d", n, NPIX); end
  endtask

  task automatic test_grant_drop();
    int n, lat, span;
    expect_frame();
    start_edge();
    run_frame(1'b0, 1'b0, 300, -1, n, lat, span);
    total++;
    if (n != NPIX) begin bad++; $display("FAIL grant_drop_count: got %0d want %0d", n, NPIX); end
  endtask

  task automatic test_level_hold();
    int n, lat, span, hits;
    expect_frame();
    start_edge();
    run_frame(1'b1, 1'b0, -1, -1, n, lat, span);
    hits = 0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if (read_request !== 1'b0 || busy !== 1'b0) hits++;
    end
    total++;
    if (hits != 0) begin bad++; $display("FAIL level_retrigger: got %0d active cycles want 0", hits); end
    image_written = 1'b0;
    repeat (2) @(posedge clk);
    expect_frame();
    start_edge();
    run_frame(1'b0, 1'b0, -1, -1, n, lat, span);
    total++;
    if (n != NPIX) begin bad++; $display("FAIL second_frame_count: got %0d want %0d", n, NPIX); end
  endtask

  task automatic test_reset_mid_frame();
    int n, lat, span, hits;
    expect_frame();
    start_edge();
    run_frame(1'b0, 1'b0, -1, 400, n, lat, span);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_frame_reset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hits = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (read_request !== 1'b0 || busy !== 1'b0 || pix_valid !== 1'b0) hits++;
    end
    total++;
    if (hits != 0) begin bad++; $display("FAIL idle_after_mid_reset: got %0d active cycles want 0", hits); end
    expect_frame();
    start_edge();
    run_frame(1'b0, 1'b0, -1, -1, n, lat, span);
    total++;
    if (n != NPIX) begin bad++; $display("FAIL restart_count: got %0d want %0d", n, NPIX); end
  endtask

  task automatic test_latency2();
    logic [8:0] e;
    int g, fv, last_c, n, gaps;
    bit fin;
    g = -1; fv = -1; last_c = -1; n = 0; gaps = 0; fin = 0;
    for (int i = 0; i < NPIX; i++) begin
      e = {1'(i == NPIX - 1), 8'(i)};
      exp2_q.push_back(e);
    end
    pix_ready2 = 1'b1;
    @(posedge clk); #1;
    image_written2 = 1'b1;
    for (int c = 0; c < 3000 && !fin; c++) begin
      @(posedge clk); #1;
      if (c == 0) image_written2 = 1'b0;
      if (g < 0 && read_request2 && read_enable2) g = c;
      if (pix_valid2) begin
        if (fv < 0) fv = c;
        total++;
        e = (exp2_q.size() != 0) ? exp2_q.pop_front() : 9'h1ff;
        if ({pix_last2, pix_data2} !== e) begin
          bad++;
          $display("FAIL lat2_pixel[%0d]: got last=%0b data=%02h want last=%0b data=%02h", n, pix_last2, pix_data2, e[8], e[7:0]);
        end
        n++;
        if (pix_last2) begin last_c = c; fin = 1; end
      end else if (fv >= 0) begin
        gaps++;
      end
    end
    total++;
    if (g < 0 || fv < 0 || fv - g - 1 != 3) begin bad++; $display("FAIL lat2_first_valid: got %0d want 3", fv - g - 1); end
    total++;
    if (gaps != 0) begin bad++; $display("FAIL lat2_gaps: got %0d want 0", gaps); end
    total++;
    if (n != NPIX || last_c < 0) begin bad++; $display("FAIL lat2_count: got %0d want %0d", n, NPIX); end
    @(posedge clk); #1;
    total++;
    if (frame_done2 !== 1'b1) begin bad++; $display("FAIL lat2_frame_done: got %0b want 1", frame_done2); end
  endtask

  initial begin
    rst_n          = 1'b0;
    image_written  = 1'b0;
    image_written2 = 1'b0;
    re_block       = 1'b0;
    pix_ready      = 1'b1;
    pix_ready2     = 1'b1;
    test_reset();
    test_basic_frame();
    test_random_ready();
    test_grant_drop();
    test_level_hold();
    test_reset_mid_frame();
    test_latency2();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
